// File: rtl/ingress_packet_parser_if.sv
// Ingress stream, loader burst, stream handshake and datapath stream of the ingress parser.
// The parser takes the slave view; whatever drives and observes it takes the master view.
interface ingress_packet_parser_if #(
  parameter int PHIT_SIZE = 512,
  parameter int RF_ADD_W  = 8
);
  logic [PHIT_SIZE-1:0] s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [PHIT_SIZE-1:0] wr_data;
  logic                 start_loader;
  logic [RF_ADD_W-1:0]  num_entry_config_table;
  logic [RF_ADD_W-1:0]  num_entry_inbound;
  logic                 start_stream_in;
  logic                 ready_stream_in;
  logic [PHIT_SIZE-1:0] m_data;
  logic                 m_valid;
  logic                 m_last;
  logic                 m_ready;
  logic                 err_hdr;
  logic                 err_len;
  logic                 err_short;

  modport slave (
    input  s_data, s_valid, s_last, ready_stream_in, m_ready,
    output s_ready, wr_data, start_loader, num_entry_config_table, num_entry_inbound,
           start_stream_in, m_data, m_valid, m_last, err_hdr, err_len, err_short
  );

  modport master (
    output s_data, s_valid, s_last, ready_stream_in, m_ready,
    input  s_ready, wr_data, start_loader, num_entry_config_table, num_entry_inbound,
           start_stream_in, m_data, m_valid, m_last, err_hdr, err_len, err_short
  );
endinterface

// File: rtl/ingress_packet_parser.sv
// Ingress packet parser: decodes the header, buffers the table/inbound load segment,
// replays it as a gap-free burst, then hands the rest of the packet to the datapath.
module ingress_packet_parser #(
  parameter int          PHIT_SIZE = 512,
  parameter int          RF_ADD_W  = 8,
  parameter int          NUM_COL   = 5,
  parameter int          DEPTH     = 64,
  parameter logic [15:0] MAGIC     = 16'hAC15
) (
  input logic                    clk,
  input logic                    rst,
  ingress_packet_parser_if.slave bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              LW      = RF_ADD_W + 4;
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_LOAD, ST_HS_REQ, ST_HS_GAP, ST_STREAM, ST_DROP
  } state_t;

  // Each config entry loads NUM_COL column tables plus the state table.
  function automatic logic [LW-1:0] load_len(input logic [RF_ADD_W-1:0] nct,
                                             input logic [RF_ADD_W-1:0] nin);
    return LW'(nct) * LW'(NUM_COL + 1) + LW'(nin);
  endfunction

  state_t                r_state, w_next;
  logic                  r_active;
  logic [RF_ADD_W-1:0]   r_nct, r_nin;
  logic [LW-1:0]         r_len;
  logic [PHIT_SIZE-1:0]  r_mem [DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [AW:0]           r_fcnt;
  logic [PHIT_SIZE-1:0]  r_wr_data;
  logic                  r_start_loader, r_err_hdr, r_err_len, r_err_short, r_last_load;

  logic [RF_ADD_W-1:0]   w_hdr_nct, w_hdr_nin;
  logic [LW-1:0]         w_len, w_fill_cnt;
  logic                  w_tag_ok, w_s_ready, w_accept;
  logic                  w_hdr, w_push, w_pop, w_flush, w_set_start;
  logic                  w_set_hdr_err, w_set_len_err, w_set_short;
  logic [PHIT_SIZE-1:0]  w_m_data;
  logic                  w_m_valid, w_m_last, w_start_stream_in;

  assign w_hdr_nct  = bus.s_data[RF_ADD_W-1:0];
  assign w_hdr_nin  = bus.s_data[2*RF_ADD_W-1:RF_ADD_W];
  assign w_tag_ok   = (bus.s_data[PHIT_SIZE-1 -: 16] == MAGIC);
  assign w_len      = load_len(w_hdr_nct, w_hdr_nin);
  assign w_fill_cnt = LW'(r_fcnt) + LW'(1);

  // r_active keeps s_ready low until the first edge after reset is released.
  assign w_s_ready = r_active && ((r_state == ST_IDLE) || (r_state == ST_FILL) ||
                                  (r_state == ST_DROP) ||
                                  ((r_state == ST_STREAM) && bus.m_ready));
  assign w_accept  = bus.s_valid && w_s_ready;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    w_hdr             = 1'b0;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_flush           = 1'b0;
    w_set_start       = 1'b0;
    w_set_hdr_err     = 1'b0;
    w_set_len_err     = 1'b0;
    w_set_short       = 1'b0;
    w_m_data          = '0;
    w_m_valid         = 1'b0;
    w_m_last          = 1'b0;
    w_start_stream_in = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_hdr = 1'b1;
          if (!w_tag_ok) begin
            w_set_hdr_err = 1'b1;
            w_next        = bus.s_last ? ST_IDLE : ST_DROP;
          end else if (w_len > DEPTH_L) begin
            w_set_len_err = 1'b1;
            w_next        = bus.s_last ? ST_IDLE : ST_DROP;
          end else if (w_len == '0) begin
            w_next = bus.s_last ? ST_IDLE : ST_HS_REQ;
          end else begin
            w_next = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (w_accept) begin
          if (w_fill_cnt == r_len) begin
            w_push      = 1'b1;
            w_set_start = 1'b1;
            w_next      = ST_LOAD;
          end else if (bus.s_last) begin
            w_set_short = 1'b1;
            w_flush     = 1'b1;
            w_next      = ST_IDLE;
          end else begin
            w_push = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        w_pop = 1'b1;
        if (r_fcnt == (AW+1)'(1)) w_next = r_last_load ? ST_IDLE : ST_HS_REQ;
      end
      ST_HS_REQ: begin
        w_start_stream_in = 1'b1;
        if (bus.ready_stream_in) w_next = ST_HS_GAP;
      end
      ST_HS_GAP: w_next = ST_STREAM;
      ST_STREAM: begin
        w_m_data  = bus.s_data;
        w_m_valid = bus.s_valid;
        w_m_last  = bus.s_last;
        if (bus.s_valid && bus.m_ready && bus.s_last) w_next = ST_IDLE;
      end
      ST_DROP: begin
        if (w_accept && bus.s_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Load buffer storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_active       <= 1'b0;
      r_nct          <= '0;
      r_nin          <= '0;
      r_len          <= '0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_fcnt         <= '0;
      r_wr_data      <= '0;
      r_start_loader <= 1'b0;
      r_err_hdr      <= 1'b0;
      r_err_len      <= 1'b0;
      r_err_short    <= 1'b0;
      r_last_load    <= 1'b0;
    end else begin
      r_active       <= 1'b1;
      r_start_loader <= w_set_start;
      r_err_hdr      <= w_set_hdr_err;
      r_err_len      <= w_set_len_err;
      r_err_short    <= w_set_short;
      if (w_hdr) begin
        r_nct <= w_hdr_nct;
        r_nin <= w_hdr_nin;
        r_len <= w_len;
      end
      if (w_set_start) r_last_load <= bus.s_last;
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_fcnt <= '0;
      end else if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
        r_fcnt <= r_fcnt + (AW+1)'(1);
      end else if (w_pop) begin
        r_rptr    <= r_rptr + AW'(1);
        r_fcnt    <= r_fcnt - (AW+1)'(1);
        r_wr_data <= r_mem[r_rptr];
      end
    end
  end

  assign bus.s_ready                = w_s_ready;
  assign bus.wr_data                = r_wr_data;
  assign bus.start_loader           = r_start_loader;
  assign bus.num_entry_config_table = r_nct;
  assign bus.num_entry_inbound      = r_nin;
  assign bus.start_stream_in        = w_start_stream_in;
  assign bus.m_data                 = w_m_data;
  assign bus.m_valid                = w_m_valid;
  assign bus.m_last                 = w_m_last;
  assign bus.err_hdr                = r_err_hdr;
  assign bus.err_len                = r_err_len;
  assign bus.err_short              = r_err_short;
endmodule

// File: tb/tb_ingress_packet_parser.sv
// Directed bench for ingress_packet_parser: good packets, backpressure, header/length/short
// errors and reset during the load burst, with hand-derived expected values.
module tb_ingress_packet_parser;
  localparam logic [15:0] MAGIC = 16'hAC15;

  logic clk;
  logic rst;
  ingress_packet_parser_if #(.PHIT_SIZE(512), .RF_ADD_W(8)) bus ();
  ingress_packet_parser dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int sl_cnt = 0, sl_cyc = 0, cap = 0, expL = 0;
  int eh_cnt = 0, el_cnt = 0, es_cnt = 0, ssi_cnt = 0;
  bit tog = 1'b0;
  bit ssi_hist [16384];
  logic [511:0] wq [$];
  logic [511:0] mq [$];
  bit           ml [$];
  int           mcq [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus.m_ready = tog ? ~bus.m_ready : 1'b1;
  end

  // Observer: records the load burst after each start_loader and every accepted output phit.
  initial forever begin
    @(negedge clk);
    if (cap > 0) begin
      wq.push_back(bus.wr_data);
      cap = cap - 1;
    end
    if (bus.start_loader) begin
      sl_cnt = sl_cnt + 1;
      sl_cyc = cyc;
      cap    = expL;
    end
    if (bus.m_valid && bus.m_ready) begin
      mq.push_back(bus.m_data);
      ml.push_back(bus.m_last);
      mcq.push_back(cyc);
    end
    if (bus.err_hdr)         eh_cnt  = eh_cnt + 1;
    if (bus.err_len)         el_cnt  = el_cnt + 1;
    if (bus.err_short)       es_cnt  = es_cnt + 1;
    if (bus.start_stream_in) ssi_cnt = ssi_cnt + 1;
    ssi_hist[cyc & 16383] = bus.start_stream_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_hdr(input logic [15:0] tag, input int nct, input int nin);
    logic [511:0] h;
    h = '0;
    h[511:496] = tag;
    h[7:0]     = 8'(nct);
    h[15:8]    = 8'(nin);
    return h;
  endfunction

  function automatic logic [511:0] mk_phit(input int id);
    logic [511:0] p;
    p = '0;
    p[511:496] = 16'h1234;
    p[255:224] = 32'(id * 7 + 3);
    p[31:0]    = 32'(id);
    return p;
  endfunction

  task automatic send(input logic [511:0] d, input bit last, output int acc);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    acc = -1;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok  = bus.s_ready;
      acc = cyc;
      @(posedge clk);
      #1;
      n = n + 1;
    end
    if (!ok) chk("accept_timeout", {511'b0, ok}, 512'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_pkt(input int nct, input int nin, input int npay, input bit gaps, input bit tgl);
    int L, h, acc, c, n, wb, mb, slb;
    L   = nct * 6 + nin;
    wb  = wq.size();
    mb  = mq.size();
    slb = sl_cnt;
    expL = L;
    send(mk_hdr(MAGIC, nct, nin), 1'b0, h);
    for (int i = 0; i < L; i++) begin
      if (gaps) idle(i % 3);
      send(mk_phit(i), (i == npay - 1), acc);
    end
    n = 0;
    while (sl_cnt == slb && n < 200) begin
      @(negedge clk);
      #1;
      n = n + 1;
    end
    if (sl_cnt == slb) chk("start_loader_timeout", 512'd0, 512'd1);
    if (!gaps) chk("start_loader_latency", 512'(sl_cyc - h), 512'(L + 1));
    n = 0;
    while (!bus.start_stream_in && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("ssi_rise", {511'b0, bus.start_stream_in}, 512'd1);
    repeat (3) begin
      @(negedge clk);
      chk("ssi_hold", {511'b0, bus.start_stream_in}, 512'd1);
    end
    @(posedge clk);
    #1;
    bus.ready_stream_in = 1'b1;
    @(negedge clk);
    c = cyc;
    @(posedge clk);
    #1;
    bus.ready_stream_in = 1'b0;
    tog = tgl;
    for (int j = L; j < npay; j++) send(mk_phit(j), (j == npay - 1), acc);
    tog = 1'b0;
    idle(4);
    chk("start_loader_once", 512'(sl_cnt - slb), 512'd1);
    chk("burst_len", 512'(wq.size() - wb), 512'(L));
    for (int k = 0; k < L; k++) chk($sformatf("burst_phit%0d", k), wq[wb + k], mk_phit(k));
    chk("wr_data_hold", bus.wr_data, mk_phit(L - 1));
    chk("ssi_at_C", {511'b0, ssi_hist[c & 16383]}, 512'd1);
    chk("ssi_gap_C1", {511'b0, ssi_hist[(c + 1) & 16383]}, 512'd0);
    if (!tgl) chk("first_m_latency", 512'(mcq[mb] - c), 512'd2);
    chk("stream_len", 512'(mq.size() - mb), 512'(npay - L));
    for (int j = 0; j < npay - L; j++) begin
      chk($sformatf("stream_phit%0d", j), mq[mb + j], mk_phit(L + j));
      chk($sformatf("stream_last%0d", j), {511'b0, ml[mb + j]}, {511'b0, (j == npay - L - 1)});
    end
    chk("nct_reg", 512'(bus.num_entry_config_table), 512'(nct));
    chk("nin_reg", 512'(bus.num_entry_inbound), 512'(nin));
  endtask

  task automatic run_drop(input logic [15:0] tag, input int nct, input int nin, input int nph,
                          input int e_hdr, input int e_len, input int e_short);
    int acc, b_eh, b_el, b_es, b_sl, b_ssi;
    b_eh = eh_cnt; b_el = el_cnt; b_es = es_cnt; b_sl = sl_cnt; b_ssi = ssi_cnt;
    expL = nct * 6 + nin;
    send(mk_hdr(tag, nct, nin), 1'b0, acc);
    for (int i = 0; i < nph; i++) send(mk_phit(100 + i), (i == nph - 1), acc);
    idle(4);
    chk("err_hdr_pulses", 512'(eh_cnt - b_eh), 512'(e_hdr));
    chk("err_len_pulses", 512'(el_cnt - b_el), 512'(e_len));
    chk("err_short_pulses", 512'(es_cnt - b_es), 512'(e_short));
    chk("no_start_loader", 512'(sl_cnt - b_sl), 512'd0);
    chk("no_handshake", 512'(ssi_cnt - b_ssi), 512'd0);
    chk("bad_nct_latched", 512'(bus.num_entry_config_table), 512'(nct));
    chk("bad_nin_latched", 512'(bus.num_entry_inbound), 512'(nin));
    @(negedge clk);
    chk("back_idle_ready", {511'b0, bus.s_ready}, 512'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, n, slb;
    rst = 1'b0;
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.ready_stream_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {511'b0, bus.s_ready}, 512'd0);
    chk("rst_start_loader", {511'b0, bus.start_loader}, 512'd0);
    chk("rst_wr_data", bus.wr_data, 512'd0);
    chk("rst_m_valid", {511'b0, bus.m_valid}, 512'd0);
    chk("rst_ssi", {511'b0, bus.start_stream_in}, 512'd0);
    chk("rst_counts", 512'({bus.num_entry_config_table, bus.num_entry_inbound}), 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("s_ready_release_cycle", {511'b0, bus.s_ready}, 512'd0);
    @(negedge clk);
    chk("s_ready_after_release", {511'b0, bus.s_ready}, 512'd1);
    @(posedge clk);
    #1;

    run_pkt(2, 3, 20, 1'b0, 1'b0);
    run_pkt(2, 3, 20, 1'b1, 1'b1);
    run_drop(16'h0000, 4, 1, 3, 1, 0, 0);
    run_pkt(2, 3, 20, 1'b0, 1'b0);
    run_pkt(10, 0, 62, 1'b0, 1'b0);
    run_drop(MAGIC, 11, 0, 3, 0, 1, 0);
    run_drop(MAGIC, 1, 1, 4, 0, 0, 1);
    run_pkt(0, 2, 5, 1'b0, 1'b0);

    // Reset asserted during the fifth cycle of the load burst.
    slb = sl_cnt;
    expL = 15;
    send(mk_hdr(MAGIC, 2, 3), 1'b0, acc);
    for (int i = 0; i < 15; i++) send(mk_phit(i), 1'b0, acc);
    n = 0;
    while (sl_cnt == slb && n < 200) begin
      @(negedge clk);
      #1;
      n = n + 1;
    end
    if (sl_cnt == slb) chk("rst_test_sl_timeout", 512'd0, 512'd1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midload_rst_wr_data", bus.wr_data, 512'd0);
    chk("midload_rst_start_loader", {511'b0, bus.start_loader}, 512'd0);
    chk("midload_rst_s_ready", {511'b0, bus.s_ready}, 512'd0);
    chk("midload_rst_counts", 512'({bus.num_entry_config_table, bus.num_entry_inbound}), 512'd0);
    chk("midload_rst_ssi_m", 512'({bus.start_stream_in, bus.m_valid, bus.m_last}), 512'd0);
    chk("midload_rst_m_data", bus.m_data, 512'd0);
    chk("midload_rst_err", 512'({bus.err_hdr, bus.err_len, bus.err_short}), 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    slb = sl_cnt;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("no_reissue_after_rst", 512'(sl_cnt - slb), 512'd0);
    run_pkt(2, 3, 20, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
